// File: rtl/time_display_mux.sv
`timescale 1ns/1ps
// Six-digit multiplexed 7-segment driver for an HH:MM:SS stopwatch.
// Takes a tear-free snapshot of the time once per scan frame and shows it as BCD.
module time_display_mux #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned TIME_W = 17;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [TIME_W-1:0] stage_a;
    logic [TIME_W-1:0] stage_b;
    logic [TIME_W-1:0] shadow;

    logic       tick_c;
    logic       load_c;
    logic [4:0] sh_hour;
    logic [5:0] sh_min;
    logic [5:0] sh_sec;
    logic [5:0] field_c;
    logic       bad_c;
    logic [3:0] digit_c;
    logic [7:0] an_c;
    logic [6:0] seg_c;
    logic       dp_c;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign tick_c  = (cnt == CNT_MAX);
    // The snapshot is taken only when the input was stable across two samples.
    assign load_c  = tick_c && (idx == 3'd5) && (stage_a == stage_b);
    assign sh_hour = shadow[16:12];
    assign sh_min  = shadow[11:6];
    assign sh_sec  = shadow[5:0];

    // Digit decode for the current slot
    always_comb begin
        field_c = sh_sec;
        bad_c   = (sh_sec > 6'd59);
        case (idx)
            3'd2, 3'd3: begin
                field_c = sh_min;
                bad_c   = (sh_min > 6'd59);
            end
            3'd4, 3'd5: begin
                field_c = 6'(sh_hour);
                bad_c   = (sh_hour > 5'd23);
            end
            default: ;
        endcase
        digit_c = idx[0] ? 4'(field_c / 6'd10) : 4'(field_c % 6'd10);
        an_c    = 8'hFF ^ (8'd1 << idx);
        seg_c   = bad_c ? SEG_DASH : seg_code(digit_c);
        if ((idx == 3'd5) && !bad_c && (sh_hour < 5'd10)) begin
            an_c  = 8'hFF;
            seg_c = SEG_BLANK;
        end
        dp_c = !((idx == 3'd2) || (idx == 3'd4));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            idx     <= '0;
            stage_a <= '0;
            stage_b <= '0;
            shadow  <= '0;
            an      <= 8'hFF;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            cnt     <= tick_c ? '0 : cnt + CNT_W'(1);
            stage_a <= {hour_in, min_in, sec_in};
            stage_b <= stage_a;
            if (tick_c) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (load_c) begin
                shadow <= stage_a;
            end
            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
`timescale 1ns/1ps
// Scoreboard bench for time_display_mux: a frame-level model predicts every cycle's
// an/seg/dp from the input history; a monitor pops and compares after each edge.
module tb_time_display_mux;

    localparam int DIV   = 4;
    localparam int FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] hour_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    time_display_mux #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .resetn(resetn),
        .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [15:0] exp_q [$];
    logic [16:0] hist [$];
    logic [16:0] m_shadow;
    int          e;
    int          checks = 0;
    int          errors = 0;

    // Expected {an, seg, dp} for a digit slot showing a given time snapshot.
    function automatic logic [15:0] expect_out(input int slot, input logic [16:0] sh);
        int h, m, s, v, lim;
        logic [7:0] a;
        logic [6:0] sg;
        logic       d;
        h   = int'(sh[16:12]);
        m   = int'(sh[11:6]);
        s   = int'(sh[5:0]);
        v   = (slot < 2) ? s : (slot < 4) ? m : h;
        lim = (slot < 4) ? 59 : 23;
        a   = 8'hFF ^ (8'd1 << slot);
        if (v > lim) begin
            sg = 7'b0111111;
        end else if (slot == 5 && h < 10) begin
            a  = 8'hFF;
            sg = 7'b1111111;
        end else begin
            sg = seg_tab[(slot % 2 == 1) ? (v / 10) : (v % 10)];
        end
        d = (slot == 2 || slot == 4) ? 1'b0 : 1'b1;
        return {a, sg, d};
    endfunction

    function automatic logic [16:0] hist_at(input int k);
        if (k < 1 || k >= hist.size()) return 17'd0;
        return hist[k];
    endfunction

    task automatic model_reset();
        e = 0;
        hist.delete();
        hist.push_back(17'd0);
        m_shadow = '0;
        exp_q.delete();
    endtask

    // Edge number e is about to happen with the given inputs visible to it.
    task automatic push_cycle(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        e = e + 1;
        hist.push_back({h, m, s});
        exp_q.push_back(expect_out(((e - 1) / DIV) % 6, m_shadow));
        if (e % FRAME == 0 && hist_at(e - 1) == hist_at(e - 2))
            m_shadow = hist_at(e - 1);
    endtask

    task automatic step(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        hour_in = h;
        min_in  = m;
        sec_in  = s;
        push_cycle(h, m, s);
    endtask

    task automatic hold(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input int n);
        repeat (n) step(h, m, s);
    endtask

    task automatic check_reset(input string tag);
        checks = checks + 1;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            errors = errors + 1;
            $display("FAIL %s: got an=%h seg=%b dp=%b, want an=ff seg=1111111 dp=1", tag, an, seg, dp);
        end
    endtask

    // Monitor: compare every post-edge output against the oldest prediction
    always begin
        logic [15:0] x;
        @(posedge clk);
        #1;
        if (resetn && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks = checks + 1;
            if ({an, seg, dp} !== x) begin
                errors = errors + 1;
                $display("FAIL scan t=%0t: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b",
                         $time, an, seg, dp, x[15:8], x[7:1], x[0]);
            end
        end
    end

    initial begin
        logic [4:0] h;
        logic [5:0] m, s;
        model_reset();
        #12;
        check_reset("reset_hold");
        @(negedge clk);
        resetn = 1'b1;
        push_cycle(5'd0, 6'd0, 6'd0);

        hold(5'd0, 6'd0, 6'd0, 3 * FRAME - 1);
        hold(5'd12, 6'd34, 6'd56, 2 * FRAME);
        hold(5'd7, 6'd5, 6'd9, 2 * FRAME);

        // Input change lands on the last sample before the snapshot edge
        while ((e + 1) % FRAME != FRAME - 1) step(5'd7, 6'd5, 6'd9);
        hold(5'd21, 6'd43, 6'd17, 2 * FRAME + 3);

        hold(5'd25, 6'd60, 6'd10, 2 * FRAME);

        repeat (40) begin
            h = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            m = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
            s = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
            hold(h, m, s, $urandom_range(1, 30));
        end
        hold(5'd18, 6'd22, 6'd33, 2 * FRAME);

        // Short asynchronous reset pulse while digit 3 is being scanned
        while (((e / DIV) % 6) != 3) step(5'd18, 6'd22, 6'd33);
        @(negedge clk);
        hour_in = 5'd12;
        min_in  = 6'd34;
        sec_in  = 6'd56;
        #2 resetn = 1'b0;
        #1 check_reset("async_reset");
        #1 resetn = 1'b1;
        model_reset();
        push_cycle(5'd12, 6'd34, 6'd56);
        hold(5'd12, 6'd34, 6'd56, 2 * FRAME + 5);

        @(posedge clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
